// File: rtl/matrix_dma_responder.sv
// Scratchpad responder for the matrix accelerator DMA port, with a CPU slot window.
// Define MATRIX_DMA_STATS_EN to add DMA read/write counters at slot addresses 5 and 6.
//
// state  | meaning
// IDLE   | waiting for dma_req while dma_en is set
// WAIT   | wait-state down-counter running
// COMMIT | scratchpad access; held while the CPU touches DATA
// ACK    | one-cycle dma_ack, dma_data_o valid for reads
module matrix_dma_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        read,
   input  logic        write,
   input  logic [4:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   input  logic        dma_req,
   output logic        dma_ack,
   input  logic [31:0] dma_addr,
   input  logic        dma_we,
   input  logic [31:0] dma_data_i,
   output logic [31:0] dma_data_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [31:0] SPAN = 32'(4 * DEPTH);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT, S_ACK} state_t;

   state_t         state, state_nxt;
   logic [31:0]    mem [DEPTH];
   logic           ctrl_en, err, busy;
   logic [AW-1:0]  ptr;
   logic [31:0]    err_addr;
   logic [31:0]    cap_addr, cap_data;
   logic           cap_we, cap_ok;
   logic [AW-1:0]  cap_idx;
   logic [3:0]     wait_cnt;
   logic           slot_acc, slot_wr, data_acc, capture, commit, fault, err_clr;
   logic           mem_we;
   logic [AW-1:0]  mem_waddr;
   logic [31:0]    mem_wdata;
   logic [32:0]    offset;
   logic           req_ok;

   assign slot_acc = cs && (read || write);
   assign slot_wr  = cs && write;
   assign data_acc = slot_acc && (addr == 5'd3);
   assign err_clr  = slot_wr && (addr == 5'd0) && wr_data[1];

   // 33-bit subtraction so an address below BASE_ADDR shows up as a borrow
   assign offset = {1'b0, dma_addr} - {1'b0, BASE_ADDR};
   assign req_ok = (dma_addr[1:0] == 2'b00) && !offset[32] && (offset[31:0] < SPAN);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (dma_req && ctrl_en) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_COMMIT;
         S_WAIT:   if (wait_cnt == 4'd0) state_nxt = S_COMMIT;
         S_COMMIT: if (!data_acc) state_nxt = S_ACK;
         S_ACK:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      dma_ack = (state == S_ACK);
      busy    = (state != S_IDLE);
      capture = (state == S_IDLE) && dma_req && ctrl_en;
      commit  = (state == S_COMMIT) && !data_acc;
      fault   = commit && !cap_ok;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_addr   <= '0;
         cap_data   <= '0;
         cap_we     <= 1'b0;
         cap_ok     <= 1'b0;
         cap_idx    <= '0;
         wait_cnt   <= '0;
         dma_data_o <= '0;
         ctrl_en    <= 1'b0;
         ptr        <= '0;
         err        <= 1'b0;
         err_addr   <= '0;
      end else begin
         if (capture) begin
            cap_addr <= dma_addr;
            cap_data <= dma_data_i;
            cap_we   <= dma_we;
            cap_ok   <= req_ok;
            cap_idx  <= offset[AW+1:2];
            wait_cnt <= WAIT_LOAD;
         end else if (state == S_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (commit && !cap_we) dma_data_o <= cap_ok ? mem[cap_idx] : 32'h0;
         if (slot_wr && addr == 5'd0) ctrl_en <= wr_data[0];
         if (slot_wr && addr == 5'd2) ptr <= wr_data[AW-1:0];
         else if (data_acc)           ptr <= ptr + 1'b1;
         // a fault in the same cycle as err_clr keeps err set
         if (fault) begin
            err <= 1'b1;
            if (!err) err_addr <= cap_addr;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end

   // CPU and DMA writes never coincide: commit is suppressed during a DATA access
   assign mem_we    = (slot_wr && addr == 5'd3) || (commit && cap_we && cap_ok);
   assign mem_waddr = (slot_wr && addr == 5'd3) ? ptr : cap_idx;
   assign mem_wdata = (slot_wr && addr == 5'd3) ? wr_data : cap_data;

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

`ifdef MATRIX_DMA_STATS_EN
   logic [31:0] rd_count, wr_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (slot_wr && (addr == 5'd5 || addr == 5'd6)) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (dma_ack) begin
         if (cap_we && wr_count != 32'hFFFF_FFFF)  wr_count <= wr_count + 32'd1;
         if (!cap_we && rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      end
   end
`endif

   always_comb begin
      rd_data = '0;
      if (cs) begin
         case (addr)
            5'd0:    rd_data = {31'b0, ctrl_en};
            5'd1:    rd_data = {30'b0, err, busy};
            5'd2:    rd_data = 32'(ptr);
            5'd3:    rd_data = mem[ptr];
            5'd4:    rd_data = err_addr;
`ifdef MATRIX_DMA_STATS_EN
            5'd5:    rd_data = rd_count;
            5'd6:    rd_data = wr_count;
`endif
            default: rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_dma_responder.sv
// Scoreboard bench for matrix_dma_responder: slot reads and DMA acks are checked
// by a negedge monitor against queues filled by the stimulus tasks.
module tb_matrix_dma_responder;

   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          WAITC = 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cs = 1'b0, read = 1'b0, write = 1'b0;
   logic [4:0]  addr = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic        dma_req = 1'b0;
   logic        dma_ack;
   logic [31:0] dma_addr = '0;
   logic        dma_we = 1'b0;
   logic [31:0] dma_data_i = '0;
   logic [31:0] dma_data_o;

   matrix_dma_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
      .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .dma_req(dma_req), .dma_ack(dma_ack),
      .dma_addr(dma_addr), .dma_we(dma_we), .dma_data_i(dma_data_i), .dma_data_o(dma_data_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_acks = 0;

   logic [31:0] exp_rd_q[$];
   logic [4:0]  exp_rd_addr_q[$];
   logic [31:0] exp_dma_data_q[$];
   logic        exp_dma_isrd_q[$];
   int          exp_dma_cyc_q[$];

   logic [31:0] mon_exp;
   logic [4:0]  mon_addr;
   logic        mon_isrd;
   int          mon_cyc;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (cs && read && !write) begin
         if (exp_rd_q.size() == 0) begin
            failures++;
            $display("FAIL slot_rd_unexpected addr=%0d got=%h", addr, rd_data);
         end else begin
            mon_exp  = exp_rd_q.pop_front();
            mon_addr = exp_rd_addr_q.pop_front();
            checks++;
            if (rd_data !== mon_exp) begin
               failures++;
               $display("FAIL slot_rd addr=%0d got=%h exp=%h", mon_addr, rd_data, mon_exp);
            end
         end
      end
      if (dma_ack) begin
         n_acks++;
         if (exp_dma_cyc_q.size() == 0) begin
            failures++;
            $display("FAIL dma_ack_unexpected cyc=%0d data=%h", cyc, dma_data_o);
         end else begin
            mon_exp  = exp_dma_data_q.pop_front();
            mon_isrd = exp_dma_isrd_q.pop_front();
            mon_cyc  = exp_dma_cyc_q.pop_front();
            checks++;
            if (cyc != mon_cyc || (mon_isrd && dma_data_o !== mon_exp)) begin
               failures++;
               $display("FAIL dma_ack cyc=%0d exp_cyc=%0d data=%h exp=%h", cyc, mon_cyc, dma_data_o, mon_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic slot_wr(input logic [4:0] a, input logic [31:0] d);
      cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; wr_data = d;
      tick();
      cs = 1'b0; write = 1'b0;
   endtask

   task automatic slot_rd(input logic [4:0] a, input logic [31:0] e);
      exp_rd_q.push_back(e);
      exp_rd_addr_q.push_back(a);
      cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
      tick();
      cs = 1'b0; read = 1'b0;
   endtask

   task automatic wait_ack();
      int n;
      n = 0;
      while (!dma_ack && n < 20) begin
         tick();
         n++;
      end
      if (!dma_ack) begin
         checks++;
         failures++;
         $display("FAIL dma_timeout addr=%h got=no_ack exp=ack", dma_addr);
         if (exp_dma_cyc_q.size() > 0) begin
            void'(exp_dma_cyc_q.pop_back());
            void'(exp_dma_data_q.pop_back());
            void'(exp_dma_isrd_q.pop_back());
         end
      end
      dma_req = 1'b0;
      tick();
   endtask

   task automatic dma_xfer(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [31:0] e);
      exp_dma_cyc_q.push_back(cyc + WAITC + 2);
      exp_dma_data_q.push_back(e);
      exp_dma_isrd_q.push_back(!we);
      dma_req = 1'b1; dma_addr = a; dma_we = we; dma_data_i = d;
      wait_ack();
   endtask

   int n0;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dma_ack !== 1'b0 || dma_data_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs ack=%b data=%h exp ack=0 data=0", dma_ack, dma_data_o);
      end
      reset_n = 1'b1;
      tick();
      slot_rd(5'd0, 32'h0);
      slot_rd(5'd1, 32'h0);
      slot_rd(5'd2, 32'h0);
      slot_rd(5'd4, 32'h0);

      // CPU load and auto-increment
      slot_wr(5'd2, 32'd0);
      slot_wr(5'd3, 32'd1);
      slot_wr(5'd3, 32'd2);
      slot_wr(5'd3, 32'd3);
      slot_wr(5'd2, 32'd0);
      slot_rd(5'd3, 32'd1);
      slot_rd(5'd3, 32'd2);
      slot_rd(5'd3, 32'd3);
      slot_rd(5'd2, 32'd3);

      // DMA read and write
      slot_wr(5'd2, 32'd2);
      slot_wr(5'd3, 32'hDEAD_BEEF);
      slot_wr(5'd0, 32'd1);
      dma_xfer(BASE + 32'd8, 1'b0, 32'h0, 32'hDEAD_BEEF);
      dma_xfer(BASE + 32'd4, 1'b1, 32'h1234_5678, 32'h0);
      slot_wr(5'd2, 32'd1);
      slot_rd(5'd3, 32'h1234_5678);

      // faults: out of range read, then misaligned write
      dma_xfer(BASE + 32'(4 * DEPTH), 1'b0, 32'h0, 32'h0);
      slot_rd(5'd1, 32'h2);
      slot_rd(5'd4, BASE + 32'(4 * DEPTH));
      dma_xfer(BASE + 32'd1, 1'b1, 32'hFFFF_FFFF, 32'h0);
      slot_rd(5'd4, BASE + 32'(4 * DEPTH));
      slot_rd(5'd1, 32'h2);
      slot_wr(5'd0, 32'd3);
      slot_rd(5'd1, 32'h0);
      slot_rd(5'd0, 32'h1);

      // CPU DATA write lands in the DMA COMMIT cycle
      slot_wr(5'd2, 32'd6);
      exp_dma_cyc_q.push_back(cyc + WAITC + 3);
      exp_dma_data_q.push_back(32'h0);
      exp_dma_isrd_q.push_back(1'b0);
      dma_req = 1'b1; dma_addr = BASE + 32'd20; dma_we = 1'b1; dma_data_i = 32'hAAAA_0005;
      for (int i = 0; i < WAITC + 1; i++) tick();
      cs = 1'b1; write = 1'b1; addr = 5'd3; wr_data = 32'h5555_0006;
      tick();
      cs = 1'b0; write = 1'b0;
      wait_ack();
      slot_wr(5'd2, 32'd5);
      slot_rd(5'd3, 32'hAAAA_0005);
      slot_rd(5'd3, 32'h5555_0006);

      // pointer wrap
      slot_wr(5'd2, 32'(DEPTH - 1));
      slot_wr(5'd3, 32'h77);
      slot_rd(5'd2, 32'h0);
      slot_wr(5'd2, 32'(DEPTH - 1));
      slot_rd(5'd3, 32'h77);
      slot_rd(5'd2, 32'h0);

      // dma_en=0 holds requests off
      slot_wr(5'd0, 32'd0);
      n0 = n_acks;
      dma_req = 1'b1; dma_addr = BASE; dma_we = 1'b0;
      repeat (10) tick();
      slot_rd(5'd1, 32'h0);
      dma_req = 1'b0;
      tick();
      checks++;
      if (n_acks != n0) begin
         failures++;
         $display("FAIL dma_en_off acks=%0d exp=%0d", n_acks - n0, 0);
      end
      slot_wr(5'd0, 32'd1);

      // reset during WAIT: no ack, no partial write
      dma_xfer(BASE + 32'd8, 1'b0, 32'h0, 32'hDEAD_BEEF);
      dma_req = 1'b1; dma_addr = BASE; dma_we = 1'b1; dma_data_i = 32'hBAD0_BAD0;
      tick();
      reset_n = 1'b0;
      dma_req = 1'b0;
      #1;
      checks++;
      if (dma_ack !== 1'b0 || dma_data_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_mid ack=%b data=%h exp ack=0 data=0", dma_ack, dma_data_o);
      end
      slot_rd(5'd1, 32'h0);
      slot_rd(5'd0, 32'h0);
      reset_n = 1'b1;
      tick();
      slot_wr(5'd0, 32'd1);
      slot_wr(5'd2, 32'd0);
      slot_rd(5'd3, 32'd1);

      // statistics (or zeros when the counters are not built)
      dma_xfer(BASE + 32'd0, 1'b0, 32'h0, 32'd1);
      dma_xfer(BASE + 32'd4, 1'b0, 32'h0, 32'h1234_5678);
      dma_xfer(BASE + 32'd8, 1'b0, 32'h0, 32'hDEAD_BEEF);
      dma_xfer(BASE + 32'd60, 1'b1, 32'h0F, 32'h0);
      dma_xfer(BASE + 32'd56, 1'b1, 32'h0E, 32'h0);
`ifdef MATRIX_DMA_STATS_EN
      slot_rd(5'd5, 32'd3);
      slot_rd(5'd6, 32'd2);
      slot_wr(5'd6, 32'd0);
      slot_rd(5'd5, 32'd0);
`else
      slot_rd(5'd5, 32'd0);
      slot_rd(5'd6, 32'd0);
`endif
      slot_rd(5'd7, 32'd0);
      slot_wr(5'd2, 32'd14);
      slot_rd(5'd3, 32'h0E);
      slot_rd(5'd3, 32'h0F);

      repeat (3) tick();
      checks++;
      if (exp_rd_q.size() != 0 || exp_dma_cyc_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain rd_left=%0d dma_left=%0d exp=0", exp_rd_q.size(), exp_dma_cyc_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
